// File: rtl/regs_wb_arbiter_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
//   REG_AW  : register address width
//   NREGS   : number of architectural registers
//   REQ_ALU : requester index of the ALU/exec writeback port
//   REQ_LSU : requester index of the load/store writeback port
package regs_wb_arbiter_pkg;
  localparam int   REG_AW  = 5;
  localparam int   NREGS   = 32;
  localparam logic REQ_ALU = 1'b0;
  localparam logic REQ_LSU = 1'b1;

  typedef logic [REG_AW-1:0] reg_addr_t;
endpackage

// File: rtl/regs_wb_arbiter_rr_arb2.sv
// Two-way round-robin arbiter.
//   clk, rst : clock, async active-high reset
//   req[1:0] : request vector, bit index = requester id
//   gnt[1:0] : one-hot grant (comb.); a grant is always a handshake,
//              because gnt is only raised for a valid requester
// On contention the requester that did not win last time is granted.
module wb_rr_arb2
  import regs_wb_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  logic last_grant;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_grant == REQ_ALU) ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  // Reset to LSU so the ALU wins the first contention.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         last_grant <= REQ_LSU;
    else if (|gnt)   last_grant <= gnt[REQ_LSU];
  end
endmodule

// File: rtl/regs_wb_arbiter.sv
// Register-file write-port sequencer with RAW scoreboard.
//   clk, rst                       : clock, async active-high reset
//   iss_valid/iss_addr/iss_ready   : decode issue of a register-writing instr
//   alu_valid/alu_addr/alu_data/alu_ready : ALU writeback request
//   lsu_valid/lsu_addr/lsu_data/lsu_ready : LSU writeback request
//   wb_we/wb_addr/wb_data          : registered register-file write port
//   rs_addr/rt_addr, rs_hazard/rt_hazard : decode source hazard lookup
//   sb_err                         : sticky, writeback with zero pending count
module regs_wb_arbiter
  import regs_wb_arbiter_pkg::*;
#(
  parameter int DW   = 32,
  parameter int CNTW = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iss_valid,
  input  logic [REG_AW-1:0] iss_addr,
  output logic              iss_ready,
  input  logic              alu_valid,
  input  logic [REG_AW-1:0] alu_addr,
  input  logic [DW-1:0]     alu_data,
  output logic              alu_ready,
  input  logic              lsu_valid,
  input  logic [REG_AW-1:0] lsu_addr,
  input  logic [DW-1:0]     lsu_data,
  output logic              lsu_ready,
  output logic              wb_we,
  output logic [REG_AW-1:0] wb_addr,
  output logic [DW-1:0]     wb_data,
  input  logic [REG_AW-1:0] rs_addr,
  input  logic [REG_AW-1:0] rt_addr,
  output logic              rs_hazard,
  output logic              rt_hazard,
  output logic              sb_err
);
  localparam logic [CNTW-1:0] CNT_MAX = '1;

  // ---------------- arbitration ----------------
  logic [1:0] gnt;
  logic       hs;
  reg_addr_t  sel_addr;
  logic [DW-1:0] sel_data;

  wb_rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req ({lsu_valid, alu_valid}),
    .gnt (gnt)
  );

  assign alu_ready = gnt[REQ_ALU];
  assign lsu_ready = gnt[REQ_LSU];
  assign hs        = |gnt;
  assign sel_addr  = gnt[REQ_LSU] ? lsu_addr : alu_addr;
  assign sel_data  = gnt[REQ_LSU] ? lsu_data : alu_data;

  // ---------------- writeback stage ----------------
  // r0 handshakes are accepted but never raise wb_we.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_we   <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
    end else if (hs) begin
      wb_we   <= (sel_addr != '0);
      wb_addr <= sel_addr;
      wb_data <= sel_data;
    end else begin
      wb_we   <= 1'b0;
    end
  end

  // ---------------- scoreboard ----------------
  logic [CNTW-1:0] cnt [NREGS];
  logic [NREGS-1:0] inc, dec, err_vec;

  assign cnt[0]     = '0;
  assign inc[0]     = 1'b0;
  assign dec[0]     = 1'b0;
  assign err_vec[0] = 1'b0;

  // Decrement happens on the edge the register file commits (wb_we high).
  for (genvar r = 1; r < NREGS; r++) begin : g_cnt
    assign inc[r]     = iss_valid & iss_ready & (iss_addr == REG_AW'(r));
    assign dec[r]     = wb_we & (wb_addr == REG_AW'(r));
    assign err_vec[r] = dec[r] & (cnt[r] == '0);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt[r] <= '0;
      else begin
        case ({inc[r], dec[r]})
          2'b10:   cnt[r] <= cnt[r] + 1'b1;
          2'b01:   if (cnt[r] != '0) cnt[r] <= cnt[r] - 1'b1;
          default: cnt[r] <= cnt[r];
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sb_err <= 1'b0;
    else     sb_err <= sb_err | (|err_vec);
  end

  assign iss_ready = (iss_addr == '0) | (cnt[iss_addr] != CNT_MAX);
  assign rs_hazard = (rs_addr != '0) & (cnt[rs_addr] != '0);
  assign rt_hazard = (rt_addr != '0) & (cnt[rt_addr] != '0);
endmodule

// File: tb/tb_regs_wb_arbiter.sv
// Directed bench: expected writebacks are pushed into a queue when the
// stimulus is issued; a monitor thread pops and compares on every wb_we.
module tb_regs_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        iss_valid;
  logic [4:0]  iss_addr;
  logic        iss_ready;
  logic        alu_valid, lsu_valid;
  logic [4:0]  alu_addr, lsu_addr;
  logic [31:0] alu_data, lsu_data;
  logic        alu_ready, lsu_ready;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [4:0]  rs_addr, rt_addr;
  logic        rs_hazard, rt_hazard, sb_err;

  regs_wb_arbiter #(.DW(32), .CNTW(2)) dut (
    .clk(clk), .rst(rst),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .iss_ready(iss_ready),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
    .lsu_valid(lsu_valid), .lsu_addr(lsu_addr), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_hazard(rs_hazard), .rt_hazard(rt_hazard), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [4:0] a; logic [31:0] d; } wb_t;
  wb_t q[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [4:0] a);
    iss_valid = 1'b1; iss_addr = a;
    #1 chk("iss_ready", iss_ready, 1);
    step();
    iss_valid = 1'b0; iss_addr = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] exp_a, exp_l;
    rst = 1'b1; iss_valid = 0; iss_addr = 0;
    alu_valid = 0; alu_addr = 0; alu_data = 0;
    lsu_valid = 0; lsu_addr = 0; lsu_data = 0;
    rs_addr = 0; rt_addr = 0;

    // Monitor: every committed write must match the next queued expectation.
    fork
      forever begin
        wb_t e;
        @(negedge clk);
        if (!rst && wb_we) begin
          if (q.size() == 0) begin
            checks++; failures++;
            $display("FAIL wb_unexpected got=addr %0d data %h exp=no write", wb_addr, wb_data);
          end else begin
            e = q.pop_front();
            chk("mon_wb_addr", 32'(wb_addr), 32'(e.a));
            chk("mon_wb_data", wb_data, e.d);
          end
        end
      end
    join_none

    // ---- reset state ----
    step(); step();
    chk("rst_wb_we", wb_we, 0);
    chk("rst_wb_addr", 32'(wb_addr), 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_sb_err", sb_err, 0);
    rst = 1'b0;

    // ---- single ALU write r5 ----
    issue(5'd5);
    rs_addr = 5'd5;
    #1 chk("r5_hazard_pend", rs_hazard, 1);
    alu_valid = 1; alu_addr = 5'd5; alu_data = 32'h1234;
    #1 chk("r5_alu_ready", alu_ready, 1);
    chk("r5_lsu_ready", lsu_ready, 0);
    q.push_back('{a: 5'd5, d: 32'h1234});
    step();
    alu_valid = 0;
    chk("r5_wb_we", wb_we, 1);
    chk("r5_wb_addr", 32'(wb_addr), 5);
    chk("r5_wb_data", wb_data, 32'h1234);
    step();
    #1 chk("r5_hazard_clr", rs_hazard, 0);
    chk("r5_wb_we_drop", wb_we, 0);

    // ---- contention: fresh reset so ALU wins first ----
    rst = 1; step(); rst = 0;
    issue(5'd3); issue(5'd4); issue(5'd3); issue(5'd4);
    exp_a = 4'b0101; exp_l = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      alu_valid = (i < 3); alu_addr = 5'd3; alu_data = 32'hA;
      lsu_valid = 1;       lsu_addr = 5'd4; lsu_data = 32'hB;
      #1 chk("rr_alu_ready", alu_ready, 32'(exp_a[i]));
      chk("rr_lsu_ready", lsu_ready, 32'(exp_l[i]));
      if (exp_a[i]) q.push_back('{a: 5'd3, d: 32'hA});
      else          q.push_back('{a: 5'd4, d: 32'hB});
      step();
    end
    alu_valid = 0; lsu_valid = 0;
    step(); step();
    chk("rr_sb_err", sb_err, 0);

    // ---- r7 issued twice, two committed writes ----
    issue(5'd7); issue(5'd7);
    rs_addr = 5'd7; rt_addr = 5'd8;
    #1 chk("r7_hazard_2", rs_hazard, 1);
    chk("r8_no_hazard", rt_hazard, 0);
    alu_valid = 1; alu_addr = 5'd7; alu_data = 32'h77;
    q.push_back('{a: 5'd7, d: 32'h77});
    step();
    alu_data = 32'h78;
    q.push_back('{a: 5'd7, d: 32'h78});
    #1 chk("r7_hazard_inflight", rs_hazard, 1);
    step();
    alu_valid = 0;
    #1 chk("r7_hazard_after1", rs_hazard, 1);
    step();
    #1 chk("r7_hazard_after2", rs_hazard, 0);

    // ---- saturation on r9 ----
    issue(5'd9); issue(5'd9); issue(5'd9);
    iss_addr = 5'd9;
    #1 chk("r9_sat_ready", iss_ready, 0);
    iss_addr = 5'd10;
    #1 chk("r10_ready", iss_ready, 1);
    iss_addr = 5'd0;

    // ---- write to r0 is dropped ----
    alu_valid = 1; alu_addr = 5'd0; alu_data = 32'hFFFF;
    #1 chk("r0_alu_ready", alu_ready, 1);
    step();
    alu_valid = 0;
    chk("r0_wb_we", wb_we, 0);
    chk("r0_wb_data", wb_data, 32'hFFFF);
    chk("r0_sb_err", sb_err, 0);

    // ---- LSU write to r12 with nothing pending ----
    lsu_valid = 1; lsu_addr = 5'd12; lsu_data = 32'hC0DE;
    #1 chk("r12_lsu_ready", lsu_ready, 1);
    q.push_back('{a: 5'd12, d: 32'hC0DE});
    step();
    lsu_valid = 0;
    step();
    chk("r12_sb_err", sb_err, 1);
    step(); step();
    chk("r12_sb_err_sticky", sb_err, 1);

    // ---- reset in the middle of an r6 write ----
    issue(5'd6);
    rs_addr = 5'd6; rt_addr = 5'd9;
    alu_valid = 1; alu_addr = 5'd6; alu_data = 32'h66;
    step();
    alu_valid = 0;
    chk("r6_wb_we_pre", wb_we, 1);
    chk("r6_hazard_pre", rs_hazard, 1);
    chk("r9_hazard_pre", rt_hazard, 1);
    #1 rst = 1;
    #1 chk("mid_rst_wb_we", wb_we, 0);
    chk("mid_rst_rs_hazard", rs_hazard, 0);
    chk("mid_rst_rt_hazard", rt_hazard, 0);
    chk("mid_rst_sb_err", sb_err, 0);
    step(); step();
    rst = 0;
    step();
    chk("post_rst_wb_we", wb_we, 0);
    step();
    chk("queue_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/regs_wb_arbiter.md
Name: regs_wb_arbiter

Overview:
- Sequences the single write port of the 32x32 CPU register file and shares it between two writeback requesters: ALU/exec (requester 0) and load/store unit (requester 1).
- Keeps a per-register pending-write scoreboard so decode can stall on RAW hazards until the write has physically landed.
- Sits between the execute/memory stages and the register file; its outputs drive the register file's write enable, write address and write data directly.

Parameters:
- DW, 32, data width of the writeback path.
- CNTW, 2, width of each per-register pending-write counter; max in-flight writes per register = 2^CNTW-1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- iss_valid  in  1  decode issues an instruction that will write iss_addr.
- iss_addr  in  5  destination register of the issued instruction.
- iss_ready  out  1  issue accepted (comb.).
- alu_valid  in  1  ALU writeback request.
- alu_addr  in  5  ALU destination register.
- alu_data  in  DW  ALU result.
- alu_ready  out  1  ALU request granted this cycle (comb.).
- lsu_valid  in  1  LSU writeback request.
- lsu_addr  in  5  LSU destination register.
- lsu_data  in  DW  load result.
- lsu_ready  out  1  LSU request granted this cycle (comb.).
- wb_we  out  1  register file write enable (registered).
- wb_addr  out  5  register file write address (registered).
- wb_data  out  DW  register file write data (registered).
- rs_addr  in  5  decode source A.
- rt_addr  in  5  decode source B.
- rs_hazard  out  1  source A has a write pending (comb.).
- rt_hazard  out  1  source B has a write pending (comb.).
- sb_err  out  1  sticky: writeback to a register with a zero pending count.

Behaviour:
- Reset (async) clears all outputs and state:
  - wb_we=0, wb_addr=0, wb_data=0, sb_err=0.
  - All 32 counters = 0.
  - Round-robin pointer last_grant=1, so requester 0 wins the first contention.
  - A reset mid-operation discards all pending grants and counts; no write is issued on the edge reset deasserts.
- Arbitration (comb.):
  - Only one requester valid: it gets ready=1.
  - Both valid: the requester not equal to last_grant gets ready; the other's ready=0.
  - last_grant updates to the winner on each accepted handshake.
  - Requesters must hold valid/addr/data stable until ready.
- Writeback stage, latency 1:
  - On a handshake, at the next edge wb_addr/wb_data are loaded with the winner's addr/data.
  - wb_we=1 only if that addr != 0; otherwise wb_we=0.
  - With no handshake, wb_we=0 and wb_addr/wb_data hold their previous values.
  - A handshake to r0 is accepted and silently dropped.
- Scoreboard:
  - cnt[r] increments at the edge where iss_valid&iss_ready and iss_addr=r, r!=0.
  - cnt[r] decrements at the edge where wb_we=1 and wb_addr=r, i.e. the edge on which the register file commits.
  - Same register incremented and decremented on the same edge: count unchanged.
  - cnt[0] is always 0.
  - iss_ready = (iss_addr==0) | (cnt[iss_addr] != 2^CNTW-1); saturation blocks issue.
  - A decrement when cnt=0 leaves the count at 0 and sets sb_err; sb_err clears only on reset.
- Hazards:
  - rs_hazard = (rs_addr!=0) & (cnt[rs_addr]!=0); rt_hazard likewise.
  - Because of asynchronous read, a hazard drops in the cycle after the committing edge, and the read then sees the new value.

Decomposition:
- Shared package holds: REG_AW=5, NREGS=32, requester index constants REQ_ALU=0 and REQ_LSU=1.
- One sub-module, wb_rr_arb2: two-way round-robin arbiter with a last_grant flop, plus the grant outputs.
- The scoreboard counter array stays in the top module.

Test Plan:
- Reset then ALU writes r5=0x1234 -> alu_ready=1 the same cycle; next cycle wb_we=1, wb_addr=5, wb_data=0x1234; lsu_ready=0.
- Both valid every cycle, ALU r3=0xA, LSU r4=0xB -> grants alternate ALU, LSU, ALU; wb_addr sequence 3,4,3; no lost or duplicated writes.
- Issue r7 twice:
  - cnt[7]=2 and rs_addr=7 gives rs_hazard=1.
  - After the first committed write of r7, hazard stays 1.
  - After the second, hazard=0 one cycle after the commit edge.
- CNTW=2, issue r9 three times -> iss_ready=0 for a fourth r9 issue; iss_ready=1 for an r10 issue the same cycle.
- ALU write to r0 with data 0xFFFF -> alu_ready=1, wb_we stays 0, sb_err=0.
- LSU write to r12 with cnt[12]=0 -> sb_err=1 and stays 1. Then assert rst mid-burst with r6 pending -> wb_we=0, all hazards 0, sb_err=0 immediately.
